// File: rtl/wb_data_ram_slave.sv
// Wishbone classic slave that shares a single-port 32-bit data RAM with a core data port.
// The core has priority; a bounded starvation counter guarantees Wishbone progress.
module wb_data_ram_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_8000,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [3:0]            core_wmask,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [31:0]           core_wdata,
  output logic                  core_gnt,
  output logic [31:0]           core_rdata,
  output logic                  ram_csb,
  output logic                  ram_web,
  output logic [3:0]            ram_wmask,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;
  localparam int unsigned CNT_W   = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, ACK} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_dat;
  logic [3:0]            r_sel;
  logic                  r_we;
  logic [CNT_W-1:0]      r_starve;
  logic                  r_ack;
  logic [31:0]           r_rdata;

  logic w_hit;
  logic w_req;
  logic w_starved;
  logic w_accept;
  logic w_unused_adr;

  // Byte offset within the word carries no information for a 32-bit RAM.
  assign w_unused_adr = &{1'b0, wbs_adr_i[1:0]};

  assign w_hit      = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign w_req      = wbs_cyc_i & wbs_stb_i & w_hit;
  assign w_starved  = (r_starve == LIMIT);

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_rdata;
  assign core_rdata = ram_dout;

  // Next state and RAM port mux; the core owns the RAM only while IDLE.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    core_gnt  = 1'b0;
    ram_csb   = 1'b1;
    ram_web   = 1'b1;
    ram_wmask = r_sel;
    ram_addr  = r_addr;
    ram_din   = r_dat;
    case (r_state)
      IDLE: begin
        w_accept  = w_req & (~core_req | w_starved);
        core_gnt  = core_req & ~w_accept;
        ram_csb   = ~core_gnt;
        ram_web   = ~core_we;
        ram_wmask = core_wmask;
        ram_addr  = core_addr;
        ram_din   = core_wdata;
        if (w_accept) begin
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        ram_csb = 1'b0;
        ram_web = ~r_we;
        w_next  = r_we ? ACK : RDATA;
      end
      RDATA:   w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_dat    <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_starve <= '0;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == ACK);
      if (w_accept) begin
        r_addr <= wbs_adr_i[TAG_LSB-1:2];
        r_dat  <= wbs_dat_i;
        r_sel  <= wbs_sel_i;
        r_we   <= wbs_we_i;
      end
      if (r_state == RDATA) begin
        r_rdata <= ram_dout;
      end
      // Counts cycles a hitting Wishbone request loses to the core.
      if (r_state == IDLE) begin
        if (w_accept || !w_req) begin
          r_starve <= '0;
        end else if (!w_starved) begin
          r_starve <= r_starve + CNT_W'(1);
        end
      end
    end
  end

endmodule
